key_debounce_multi: RTL and testbench
=====================================

Name: key_debounce_multi

Overview:
- Parametrised N-channel push-button front end; successor to the single-key capture-and-LED-toggle block.
- Each channel has:
  - a 2-flop synchroniser;
  - a per-channel debounce FSM with its own counter;
  - one-cycle press, release, long-press and auto-repeat pulses;
  - a debounced level and a toggle register (the LED-toggle function, now per key).
- Sits between board key pins and control logic or LEDs, in the clk_i domain.

Parameters:
- N_KEYS, 4, number of independent key channels (1..16).
- DEB_CYCLES, 1000000, clock cycles a new level must be stable before it is accepted (20 ms at 50 MHz); minimum 2.
- LONG_CYCLES, 50000000, cycles in HELD before long_o fires; must be greater than DEB_CYCLES.
- REPEAT_CYCLES, 10000000, repeat_o period while in LONG; 0 disables repeat.
- ACTIVE_LOW, 1, 1 means a key reads 0 when pressed (inverted after the synchroniser); 0 means it reads 1 when pressed.

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  reset
- key_i  input  N_KEYS  raw asynchronous key pins
- level_o  output  N_KEYS  debounced pressed state, 1 = pressed
- press_o  output  N_KEYS  one-cycle pulse on accepted press
- release_o  output  N_KEYS  one-cycle pulse on accepted release
- long_o  output  N_KEYS  one-cycle pulse when hold reaches LONG_CYCLES
- repeat_o  output  N_KEYS  one-cycle pulse every REPEAT_CYCLES in LONG
- toggle_o  output  N_KEYS  inverts on every press_o

Interface (already decided): reset rst_n_i, asynchronous, active-low; clock clk_i.

Behaviour:
- Reset:
  - All outputs 0, all FSMs IDLE, counters 0.
  - Synchroniser flops reset to the released level (1 if ACTIVE_LOW, else 0).
  - Assertion mid-operation aborts every channel immediately; no pulse is emitted on reset.
- All outputs are registered. Channels are fully independent; simultaneous events on any channels are all reported in the same cycle.
- p denotes the synchronised, polarity-normalised key: 1 = pressed.
- Counter width is $clog2 of the largest of DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES. The counter never wraps: it always clears on the terminal count.
- FSM per channel:
  - IDLE:
    - p=1 -> DEB_PRESS, cnt=0.
  - DEB_PRESS:
    - p=0 -> IDLE (glitch rejected, no output).
    - Else cnt++.
    - At cnt==DEB_CYCLES-1 with p=1 -> HELD: cnt=0, level_o=1, press_o=1 for 1 cycle, toggle_o inverts, was_long=0.
  - HELD:
    - p=0 -> DEB_REL, cnt=0.
    - Else cnt++.
    - At cnt==LONG_CYCLES-1 -> LONG: cnt=0, long_o=1 for 1 cycle, was_long=1.
  - LONG:
    - p=0 -> DEB_REL, cnt=0.
    - Else, if REPEAT_CYCLES>0: cnt++; at cnt==REPEAT_CYCLES-1, repeat_o=1 for 1 cycle and cnt=0.
  - DEB_REL:
    - p=1 -> back to HELD (was_long=0) or LONG (was_long=1), cnt=0. Release bounce is rejected with no pulse; the long/repeat timer restarts.
    - Else cnt++.
    - At cnt==DEB_CYCLES-1 -> IDLE: level_o=0, release_o=1 for 1 cycle.
- Latency:
  - Numbering the edge at which the first synchroniser flop captures a stable press as edge 0:
    - sync output is high after edge 1;
    - DEB_PRESS is entered at edge 2;
    - press_o and level_o go high at edge DEB_CYCLES+2.
  - Release latency is identical (release_o at edge DEB_CYCLES+2).
  - long_o fires exactly LONG_CYCLES edges after press_o. First repeat_o fires REPEAT_CYCLES edges after long_o, then periodically.
- press_o, long_o, repeat_o and release_o are mutually exclusive per channel in any cycle.
- A pulse shorter than DEB_CYCLES produces no output and no toggle.

Test Plan (DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, N_KEYS=4, ACTIVE_LOW=1):
- Clean press:
  - Stimulus: key_i[0] 1->0 and held 40 cycles, then released.
  - Required: press_o[0] at edge 6 exactly; level_o[0]=1; toggle_o[0]=1; long_o[0] 20 edges after press; repeat_o[0] every 5 edges thereafter; release_o[0] 6 edges after release; level_o[0]=0.
- Bounce rejection:
  - Stimulus: key_i[1] low 3 cycles, high 1, low 3, high; later a stable press with 2-cycle release glitches.
  - Required: no pulse from the 3-cycle bursts; exactly one press_o[1] and one release_o[1]; glitch returns the FSM to HELD with no release.
- Simultaneous channels:
  - Stimulus: key_i = 4'b0000 asserted on the same edge.
  - Required: press_o=4'b1111 in a single cycle; toggle_o=4'b1111; staggered releases give independent release_o bits.
- Toggle:
  - Stimulus: 3 complete press/release cycles on key 2.
  - Required: toggle_o[2] sequence 1,0,1; no toggle on release.
- Reset mid-operation:
  - Stimulus: assert rst_n_i while key 3 is in LONG and key 0 is in DEB_PRESS.
  - Required: all outputs 0 asynchronously; no pulses after deassertion until a fresh full debounce completes.
- Repeat disabled (REPEAT_CYCLES=0):
  - Stimulus: hold key 0 for 100 cycles.
  - Required: one long_o, zero repeat_o.

Source files
------------

// File: rtl/key_debounce_multi_if.sv
// key_debounce_multi_if: raw key pins in, debounced level and event pulses out.
interface key_debounce_multi_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_i;
    logic [N_KEYS-1:0] level_o;
    logic [N_KEYS-1:0] press_o;
    logic [N_KEYS-1:0] release_o;
    logic [N_KEYS-1:0] long_o;
    logic [N_KEYS-1:0] repeat_o;
    logic [N_KEYS-1:0] toggle_o;
    modport master (
        output key_i,
        input  level_o, press_o, release_o, long_o, repeat_o, toggle_o
    );
    modport slave (
        input  key_i,
        output level_o, press_o, release_o, long_o, repeat_o, toggle_o
    );
endinterface

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: per-key synchroniser and debounce FSM producing level,
// toggle and one-cycle press/release/long/repeat pulses.
module key_debounce_multi #(
    parameter int N_KEYS        = 4,
    parameter int DEB_CYCLES    = 1000000,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input logic                 clk_i,
    input logic                 rst_n_i,
    key_debounce_multi_if.slave bus
);
    localparam int MAX_DL = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
    localparam int MAX_C  = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
    localparam int CW     = $clog2(MAX_C);
    localparam logic [CW-1:0] DEB_T  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] LONG_T = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_T  = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [N_KEYS-1:0] REL_LVL = {N_KEYS{ACTIVE_LOW}};

    typedef enum logic [2:0] {IDLE, DEB_PRESS, HELD, LONG, DEB_REL} state_t;

    logic [N_KEYS-1:0] r_sync1, r_sync2, w_p;
    state_t            r_state [N_KEYS];
    state_t            w_state [N_KEYS];
    logic [CW-1:0]     r_cnt [N_KEYS];
    logic [CW-1:0]     w_cnt [N_KEYS];
    logic [N_KEYS-1:0] r_was_long, w_was_long;
    logic [N_KEYS-1:0] w_press, w_release, w_long, w_repeat;
    logic [N_KEYS-1:0] r_level, r_press, r_release, r_long, r_repeat, r_toggle;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync1 <= REL_LVL;
            r_sync2 <= REL_LVL;
        end else begin
            r_sync1 <= bus.key_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_p = r_sync2 ^ REL_LVL;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < N_KEYS; k++) begin
                r_state[k] <= IDLE;
                r_cnt[k]   <= '0;
            end
            r_was_long <= '0;
        end else begin
            for (int k = 0; k < N_KEYS; k++) begin
                r_state[k] <= w_state[k];
                r_cnt[k]   <= w_cnt[k];
            end
            r_was_long <= w_was_long;
        end
    end

    // Every exit from a state restarts the counter, so it never needs to wrap.
    always_comb begin
        w_press    = '0;
        w_release  = '0;
        w_long     = '0;
        w_repeat   = '0;
        w_was_long = r_was_long;
        for (int k = 0; k < N_KEYS; k++) begin
            w_state[k] = r_state[k];
            w_cnt[k]   = r_cnt[k];
            case (r_state[k])
                IDLE: if (w_p[k]) begin
                    w_state[k] = DEB_PRESS;
                    w_cnt[k]   = '0;
                end
                DEB_PRESS: if (!w_p[k]) begin
                    w_state[k] = IDLE;
                    w_cnt[k]   = '0;
                end else if (r_cnt[k] == DEB_T) begin
                    w_state[k]    = HELD;
                    w_cnt[k]      = '0;
                    w_press[k]    = 1'b1;
                    w_was_long[k] = 1'b0;
                end else w_cnt[k] = r_cnt[k] + 1'b1;
                HELD: if (!w_p[k]) begin
                    w_state[k] = DEB_REL;
                    w_cnt[k]   = '0;
                end else if (r_cnt[k] == LONG_T) begin
                    w_state[k]    = LONG;
                    w_cnt[k]      = '0;
                    w_long[k]     = 1'b1;
                    w_was_long[k] = 1'b1;
                end else w_cnt[k] = r_cnt[k] + 1'b1;
                LONG: if (!w_p[k]) begin
                    w_state[k] = DEB_REL;
                    w_cnt[k]   = '0;
                end else if (REPEAT_CYCLES > 0) begin
                    w_repeat[k] = (r_cnt[k] == REP_T);
                    w_cnt[k]    = (r_cnt[k] == REP_T) ? '0 : r_cnt[k] + 1'b1;
                end
                DEB_REL: if (w_p[k]) begin
                    w_state[k] = r_was_long[k] ? LONG : HELD;
                    w_cnt[k]   = '0;
                end else if (r_cnt[k] == DEB_T) begin
                    w_state[k]   = IDLE;
                    w_cnt[k]     = '0;
                    w_release[k] = 1'b1;
                end else w_cnt[k] = r_cnt[k] + 1'b1;
                default: begin
                    w_state[k] = IDLE;
                    w_cnt[k]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_long    <= '0;
            r_repeat  <= '0;
            r_toggle  <= '0;
        end else begin
            r_level   <= (r_level | w_press) & ~w_release;
            r_press   <= w_press;
            r_release <= w_release;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            r_toggle  <= r_toggle ^ w_press;
        end
    end

    assign bus.level_o   = r_level;
    assign bus.press_o   = r_press;
    assign bus.release_o = r_release;
    assign bus.long_o    = r_long;
    assign bus.repeat_o  = r_repeat;
    assign bus.toggle_o  = r_toggle;
endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: directed tables, hand sequences and random keys checked
// against a run-length based reference model, for repeat enabled and disabled.
module tb_key_debounce_multi;
    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 5;

    logic clk_i, rst_n_i;
    key_debounce_multi_if #(.N_KEYS(4)) bus();
    key_debounce_multi_if #(.N_KEYS(4)) bus0();

    key_debounce_multi #(.N_KEYS(4), .DEB_CYCLES(DEB), .LONG_CYCLES(LNG),
        .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus));
    key_debounce_multi #(.N_KEYS(4), .DEB_CYCLES(DEB), .LONG_CYCLES(LNG),
        .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b1)) dut0 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus0));

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    logic [3:0] km, kz;

    logic [3:0] m_s1[2], m_s2[2], m_prev[2], m_lv[2], m_tg[2], m_wl[2];
    int         m_run[2][4], m_age[2][4];
    logic [3:0] e_pr[2], e_rl[2], e_lg[2], e_rp[2];

    logic [3:0] acc_pr, acc_rl;
    int         c0_long, c0_rep;
    logic [3:0] rq[$];

    typedef struct {
        logic [3:0] key;
        int         cycles;
        logic [3:0] e_press;
        logic [3:0] e_rel;
        logic [3:0] e_level;
    } seg_t;
    seg_t segs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_s1[m] = '0; m_s2[m] = '0; m_prev[m] = '0;
            m_lv[m] = '0; m_tg[m] = '0; m_wl[m] = '0;
            for (int c = 0; c < 4; c++) begin
                m_run[m][c] = 0;
                m_age[m][c] = 0;
            end
        end
    endtask

    // Events follow from how long the pressed signal has been stable and how
    // long the key has been held since the hold timer last restarted.
    task automatic model_step();
        logic [3:0] raw;
        logic       p;
        int         rep;
        for (int m = 0; m < 2; m++) begin
            rep = (m == 0) ? REP : 0;
            raw = (m == 0) ? km : kz;
            e_pr[m] = '0; e_rl[m] = '0; e_lg[m] = '0; e_rp[m] = '0;
            for (int c = 0; c < 4; c++) begin
                p = m_s2[m][c];
                m_run[m][c] = (p == m_prev[m][c]) ? m_run[m][c] + 1 : 1;
                m_prev[m][c] = p;
                if (!m_lv[m][c]) begin
                    if (p && m_run[m][c] > DEB) begin
                        e_pr[m][c] = 1'b1;
                        m_lv[m][c] = 1'b1;
                        m_tg[m][c] = ~m_tg[m][c];
                        m_wl[m][c] = 1'b0;
                        m_age[m][c] = 0;
                    end
                end else if (!p) begin
                    if (m_run[m][c] > DEB) begin
                        e_rl[m][c] = 1'b1;
                        m_lv[m][c] = 1'b0;
                    end
                end else if (m_run[m][c] == 1) begin
                    m_age[m][c] = 0;
                end else begin
                    m_age[m][c]++;
                    if (!m_wl[m][c] && m_age[m][c] == LNG) begin
                        e_lg[m][c] = 1'b1;
                        m_wl[m][c] = 1'b1;
                        m_age[m][c] = 0;
                    end else if (m_wl[m][c] && rep > 0 && m_age[m][c] % rep == 0) begin
                        e_rp[m][c] = 1'b1;
                    end
                end
            end
            m_s2[m] = m_s1[m];
            m_s1[m] = ~raw;
        end
    endtask

    task automatic tick();
        bus.key_i  = km;
        bus0.key_i = kz;
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        check("dut_outputs",
            {bus.level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o, bus.toggle_o},
            {m_lv[0], e_pr[0], e_rl[0], e_lg[0], e_rp[0], m_tg[0]});
        check("dut0_outputs",
            {bus0.level_o, bus0.press_o, bus0.release_o, bus0.long_o, bus0.repeat_o, bus0.toggle_o},
            {m_lv[1], e_pr[1], e_rl[1], e_lg[1], e_rp[1], m_tg[1]});
        acc_pr  |= bus.press_o;
        acc_rl  |= bus.release_o;
        c0_long += int'(bus0.long_o[0]);
        c0_rep  += int'(bus0.repeat_o[0]);
        if (bus.release_o != 4'h0) rq.push_back(bus.release_o);
    endtask

    initial begin
        int i;
        int rem[8];
        logic [7:0] rk;
        segs[0] = '{4'hD, 3,  4'h0, 4'h0, 4'h0};
        segs[1] = '{4'hF, 1,  4'h0, 4'h0, 4'h0};
        segs[2] = '{4'hD, 3,  4'h0, 4'h0, 4'h0};
        segs[3] = '{4'hF, 8,  4'h0, 4'h0, 4'h0};
        segs[4] = '{4'hD, 8,  4'h2, 4'h0, 4'h2};
        segs[5] = '{4'hF, 2,  4'h0, 4'h0, 4'h2};
        segs[6] = '{4'hD, 6,  4'h0, 4'h0, 4'h2};
        segs[7] = '{4'hF, 2,  4'h0, 4'h0, 4'h2};
        segs[8] = '{4'hD, 6,  4'h0, 4'h0, 4'h2};
        segs[9] = '{4'hF, 10, 4'h0, 4'h2, 4'h0};
        acc_pr = '0; acc_rl = '0; c0_long = 0; c0_rep = 0;
        km = 4'hF; kz = 4'hF;
        bus.key_i = km; bus0.key_i = kz;
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_main", {bus.level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o, bus.toggle_o}, 0);
        check("reset_rep0", {bus0.level_o, bus0.press_o, bus0.release_o, bus0.long_o, bus0.repeat_o, bus0.toggle_o}, 0);
        model_reset();
        rst_n_i = 1'b1;

        km = 4'hE;
        for (i = 0; i < 20; i++) begin tick(); if (bus.press_o[0]) break; end
        check("press_edge", i, DEB + 2);
        check("press_level", bus.level_o[0], 1);
        check("press_toggle", bus.toggle_o[0], 1);
        for (i = 1; i < 40; i++) begin tick(); if (bus.long_o[0]) break; end
        check("long_delay", i, LNG);
        for (int r = 0; r < 2; r++) begin
            for (i = 1; i < 20; i++) begin tick(); if (bus.repeat_o[0]) break; end
            check("repeat_period", i, REP);
        end
        km = 4'hF;
        for (i = 0; i < 20; i++) begin tick(); if (bus.release_o[0]) break; end
        check("release_edge", i, DEB + 2);
        check("release_level", bus.level_o[0], 0);
        repeat (8) tick();

        for (int s = 0; s < 10; s++) begin
            acc_pr = '0; acc_rl = '0;
            km = segs[s].key;
            repeat (segs[s].cycles) tick();
            check($sformatf("seg%0d_press", s), acc_pr, segs[s].e_press);
            check($sformatf("seg%0d_release", s), acc_rl, segs[s].e_rel);
            check($sformatf("seg%0d_level", s), bus.level_o, segs[s].e_level);
        end

        km = 4'h0;
        for (i = 0; i < 20; i++) begin tick(); if (bus.press_o != 4'h0) break; end
        check("simul_press", bus.press_o, 4'hF);
        check("simul_toggle", bus.toggle_o, 4'hC);
        rq.delete();
        km = 4'h1; repeat (3) tick();
        km = 4'h3; repeat (3) tick();
        km = 4'h7; repeat (3) tick();
        km = 4'hF; repeat (12) tick();
        check("stagger_count", rq.size(), 4);
        for (int r = 0; r < 4 && r < rq.size(); r++)
            check($sformatf("stagger_rel%0d", r), rq[r], 4'h1 << r);

        km = 4'h7; repeat (30) tick();
        km = 4'h6; repeat (4) tick();
        check("pre_reset_level", bus.level_o, 4'h8);
        #2 rst_n_i = 1'b0;
        #1 check("async_reset", {bus.level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o, bus.toggle_o}, 0);
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("held_reset", {bus.level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o, bus.toggle_o}, 0);
        rst_n_i = 1'b1;
        for (i = 0; i < 20; i++) begin tick(); if (bus.press_o != 4'h0) break; end
        check("post_reset_edge", i, DEB + 2);
        check("post_reset_press", bus.press_o, 4'h9);
        km = 4'hF; repeat (12) tick();

        for (int r = 0; r < 3; r++) begin
            km = 4'hB; repeat (10) tick();
            check($sformatf("toggle_press%0d", r), bus.toggle_o[2], (r % 2 == 0));
            km = 4'hF; repeat (10) tick();
            check($sformatf("toggle_release%0d", r), bus.toggle_o[2], (r % 2 == 0));
        end

        c0_long = 0; c0_rep = 0;
        kz = 4'hE; repeat (100) tick();
        kz = 4'hF; repeat (10) tick();
        check("norep_long", c0_long, 1);
        check("norep_repeat", c0_rep, 0);

        rk = 8'hFF;
        for (int c = 0; c < 8; c++) rem[c] = 0;
        for (int t = 0; t < 2000; t++) begin
            for (int c = 0; c < 8; c++) begin
                if (rem[c] == 0) begin
                    rk[c] = ~rk[c];
                    rem[c] = $urandom_range(0, 1) ? int'($urandom_range(1, 6)) : int'($urandom_range(8, 60));
                end
                rem[c]--;
            end
            km = rk[3:0];
            kz = rk[7:4];
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
